// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DefaultTimeout = 255;

  typedef enum logic [1:0] {
    StIdle,
    StIBusy,
    StDBusy
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch-side, MEM-stage and shared memory-port signals of the arbiter.
interface mem_arbiter_if;

  logic        i_IReq;
  logic [31:0] i_IAddr;
  logic        i_DRead;
  logic        i_DWrite;
  logic [31:0] i_DAddr;
  logic [31:0] i_DWData;
  logic        o_MemReq;
  logic        o_MemWe;
  logic [31:0] o_MemAddr;
  logic [31:0] o_MemWData;
  logic        i_MemAck;
  logic [31:0] i_MemRData;
  logic [31:0] o_IRData;
  logic        o_IDone;
  logic        o_IStall;
  logic [31:0] o_DRData;
  logic        o_DDone;
  logic        o_DStall;
  logic        o_BusErr;

  // Arbiter view.
  modport master (
    input  i_IReq, i_IAddr, i_DRead, i_DWrite, i_DAddr, i_DWData, i_MemAck, i_MemRData,
    output o_MemReq, o_MemWe, o_MemAddr, o_MemWData, o_IRData, o_IDone, o_IStall,
    output o_DRData, o_DDone, o_DStall, o_BusErr
  );

  // Requester/memory environment view.
  modport slave (
    output i_IReq, i_IAddr, i_DRead, i_DWrite, i_DAddr, i_DWData, i_MemAck, i_MemRData,
    input  o_MemReq, o_MemWe, o_MemAddr, o_MemWData, o_IRData, o_IDone, o_IStall,
    input  o_DRData, o_DDone, o_DStall, o_BusErr
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// Saturating BUSY-cycle counter; hit flags the cycle whose increment reaches Limit.
module mem_timeout_cnt #(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic hit
);

  localparam int unsigned CntW = $clog2(Limit + 1);
  localparam logic [CntW-1:0] LimitC = CntW'(Limit);
  localparam logic [CntW-1:0] LimitM1 = CntW'(Limit - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LimitC)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit = en && (cnt_q >= LimitM1);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one shared memory port, with timeout abort.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input logic           i_Clk,
  input logic           Reset,
  mem_arbiter_if.master bus
);

  arb_state_e  state_q, state_d;
  logic        last_d_q, last_d_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] irdata_q, irdata_d, drdata_q, drdata_d;
  logic        idone_q, idone_d, ddone_q, ddone_d, berr_q, berr_d;
  logic        d_pend, i_pend, grant_d, grant_i, busy, hit, ack;

  assign d_pend  = bus.i_DRead | bus.i_DWrite;
  assign i_pend  = bus.i_IReq;
  // On contention D wins unless D held the port last.
  assign grant_d = d_pend && (!i_pend || !last_d_q);
  assign grant_i = i_pend && !grant_d;
  assign busy    = (state_q != StIdle);
  assign ack     = bus.i_MemAck;

  mem_timeout_cnt #(
    .Limit(TIMEOUT)
  ) u_timeout_cnt (
    .clk(i_Clk),
    .rst(Reset),
    .en (busy),
    .clr(!busy),
    .hit(hit)
  );

  always_ff @(posedge i_Clk) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d)      state_d = StDBusy;
        else if (grant_i) state_d = StIBusy;
      end
      StIBusy, StDBusy: begin
        if (ack || hit) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_d_d    = last_d_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    idone_d     = 1'b0;
    ddone_d     = 1'b0;
    berr_d      = berr_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.i_DWrite;
          mem_addr_d  = {bus.i_DAddr[31:2], 2'b00};
          mem_wdata_d = bus.i_DWrite ? bus.i_DWData : 32'h0;
        end else if (grant_i) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {bus.i_IAddr[31:2], 2'b00};
          mem_wdata_d = 32'h0;
        end
      end
      StIBusy: begin
        if (ack || hit) begin
          mem_req_d = 1'b0;
          idone_d   = 1'b1;
          last_d_d  = 1'b0;
          irdata_d  = ack ? bus.i_MemRData : 32'h0;
          if (!ack) berr_d = 1'b1;
        end
      end
      StDBusy: begin
        if (ack || hit) begin
          mem_req_d = 1'b0;
          ddone_d   = 1'b1;
          last_d_d  = 1'b1;
          if (!mem_we_q) drdata_d = ack ? bus.i_MemRData : 32'h0;
          if (!ack) berr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (Reset) begin
      last_d_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      irdata_q    <= 32'h0;
      drdata_q    <= 32'h0;
      idone_q     <= 1'b0;
      ddone_q     <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      last_d_q    <= last_d_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
      idone_q     <= idone_d;
      ddone_q     <= ddone_d;
      berr_q      <= berr_d;
    end
  end

  assign bus.o_MemReq   = mem_req_q;
  assign bus.o_MemWe    = mem_we_q;
  assign bus.o_MemAddr  = mem_addr_q;
  assign bus.o_MemWData = mem_wdata_q;
  assign bus.o_IRData   = irdata_q;
  assign bus.o_DRData   = drdata_q;
  assign bus.o_IDone    = idone_q;
  assign bus.o_DDone    = ddone_q;
  assign bus.o_BusErr   = berr_q;
  assign bus.o_IStall   = i_pend & ~idone_q;
  assign bus.o_DStall   = d_pend & ~ddone_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; a second instance covers the timeout path.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc_n = 0;
  int   t_prev = 0;
  int   t_now = 0;
  bit   is_d;

  mem_arbiter_if bus ();
  mem_arbiter_if bus2 ();

  mem_arbiter dut (
    .i_Clk(clk),
    .Reset(rst),
    .bus  (bus)
  );

  mem_arbiter #(
    .TIMEOUT(4)
  ) dut_to (
    .i_Clk(clk),
    .Reset(rst),
    .bus  (bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_IReq = 0;  bus.i_IAddr = 0;  bus.i_DRead = 0;  bus.i_DWrite = 0;
    bus.i_DAddr = 0; bus.i_DWData = 0; bus.i_MemAck = 0; bus.i_MemRData = 0;
    bus2.i_IReq = 0;  bus2.i_IAddr = 0;  bus2.i_DRead = 0;  bus2.i_DWrite = 0;
    bus2.i_DAddr = 0; bus2.i_DWData = 0; bus2.i_MemAck = 0; bus2.i_MemRData = 0;
    cyc(2);
    rst = 1'b0;

    // Reset state
    chk("rst_memreq", bus.o_MemReq, 32'd0);
    chk("rst_memaddr", bus.o_MemAddr, 32'd0);
    chk("rst_memwe", bus.o_MemWe, 32'd0);
    chk("rst_irdata", bus.o_IRData, 32'd0);
    chk("rst_done", {bus.o_IDone, bus.o_DDone, bus.o_BusErr}, 32'd0);

    // Single fetch, ack on first BUSY cycle
    bus.i_IReq = 1; bus.i_IAddr = 32'h0040_0006;
    cyc(1);
    chk("f_req", bus.o_MemReq, 32'd1);
    chk("f_addr", bus.o_MemAddr, 32'h0040_0004);
    chk("f_we", bus.o_MemWe, 32'd0);
    chk("f_stall", bus.o_IStall, 32'd1);
    bus.i_MemAck = 1; bus.i_MemRData = 32'h8C01_0004;
    cyc(1);
    chk("f_done", bus.o_IDone, 32'd1);
    chk("f_rdata", bus.o_IRData, 32'h8C01_0004);
    chk("f_req_drop", bus.o_MemReq, 32'd0);
    chk("f_stall_rel", bus.o_IStall, 32'd0);
    bus.i_IReq = 0; bus.i_MemAck = 0;
    cyc(1);
    chk("f_done_pulse", bus.o_IDone, 32'd0);
    chk("f_rdata_hold", bus.o_IRData, 32'h8C01_0004);

    // Ack while idle is ignored
    bus.i_MemAck = 1; bus.i_MemRData = 32'h7777_7777;
    cyc(1);
    chk("idle_ack", {bus.o_MemReq, bus.o_IDone, bus.o_DDone}, 32'd0);
    chk("idle_ack_data", bus.o_IRData, 32'h8C01_0004);
    bus.i_MemAck = 0;

    // Simultaneous fetch and store: D first, then I
    bus.i_IReq = 1; bus.i_IAddr = 32'h0040_0010;
    bus.i_DWrite = 1; bus.i_DAddr = 32'h1001_0000; bus.i_DWData = 32'hDEAD_BEEF;
    cyc(1);
    chk("c_d_addr", bus.o_MemAddr, 32'h1001_0000);
    chk("c_d_we", bus.o_MemWe, 32'd1);
    chk("c_d_wdata", bus.o_MemWData, 32'hDEAD_BEEF);
    chk("c_stalls", {bus.o_IStall, bus.o_DStall}, 32'd3);
    bus.i_MemAck = 1; bus.i_MemRData = 32'h1234_5678;
    cyc(1);
    chk("c_d_done", bus.o_DDone, 32'd1);
    chk("c_istall_d", bus.o_IStall, 32'd1);
    chk("c_drdata_wr", bus.o_DRData, 32'd0);
    bus.i_DWrite = 0; bus.i_MemAck = 0;
    cyc(1);
    chk("c_i_addr", bus.o_MemAddr, 32'h0040_0010);
    chk("c_i_we", {bus.o_MemWe, bus.o_MemReq}, 32'd1);
    chk("c_i_wdata", bus.o_MemWData, 32'd0);
    chk("c_istall_i", bus.o_IStall, 32'd1);
    bus.i_MemAck = 1; bus.i_MemRData = 32'h0BAD_F00D;
    cyc(1);
    chk("c_i_done", bus.o_IDone, 32'd1);
    chk("c_i_rdata", bus.o_IRData, 32'h0BAD_F00D);
    bus.i_IReq = 0; bus.i_MemAck = 0;
    cyc(1);

    // Both held pending, ack sampled on the fourth BUSY cycle
    bus.i_IReq = 1; bus.i_IAddr = 32'h0040_0020;
    bus.i_DRead = 1; bus.i_DAddr = 32'h1001_0020;
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      is_d = (k % 2 == 0);
      chk("alt_req", bus.o_MemReq, 32'd1);
      chk("alt_addr", bus.o_MemAddr, is_d ? 32'h1001_0020 : 32'h0040_0020);
      cyc(3);
      chk("alt_wait", {bus.o_MemReq, bus.o_IDone, bus.o_DDone}, 32'd4);
      bus.i_MemAck = 1;
      bus.i_MemRData = is_d ? 32'hD000_0000 + 32'(k) : 32'h1000_0000 + 32'(k);
      cyc(1);
      bus.i_MemAck = 0;
      chk("alt_done", {bus.o_IDone, bus.o_DDone}, is_d ? 32'd1 : 32'd2);
      chk("alt_rdata", is_d ? bus.o_DRData : bus.o_IRData,
          is_d ? 32'hD000_0000 + 32'(k) : 32'h1000_0000 + 32'(k));
      chk("alt_istall", bus.o_IStall, is_d ? 32'd1 : 32'd0);
      t_now = cyc_n;
      if (k > 0) chk("alt_gap", 32'(t_now - t_prev), 32'd5);
      t_prev = t_now;
      if (k == 3) begin
        bus.i_IReq = 0; bus.i_DRead = 0;
      end
      cyc(1);
    end
    chk("alt_quiet", bus.o_MemReq, 32'd0);

    // D read with unaligned address
    bus.i_DRead = 1; bus.i_DAddr = 32'h1001_0007; bus.i_DWData = 32'hFFFF_FFFF;
    cyc(1);
    chk("dr_addr", bus.o_MemAddr, 32'h1001_0004);
    chk("dr_we", {bus.o_MemWe, bus.o_MemWData}, 32'd0);
    bus.i_MemAck = 1; bus.i_MemRData = 32'h1122_3344;
    cyc(1);
    chk("dr_data", bus.o_DRData, 32'h1122_3344);
    bus.i_DRead = 0; bus.i_MemAck = 0;
    cyc(1);

    // Read and write together behave as a write
    bus.i_DRead = 1; bus.i_DWrite = 1; bus.i_DAddr = 32'h1001_0008; bus.i_DWData = 32'hCAFE_F00D;
    cyc(1);
    chk("rw_we", bus.o_MemWe, 32'd1);
    chk("rw_wdata", bus.o_MemWData, 32'hCAFE_F00D);
    bus.i_MemAck = 1; bus.i_MemRData = 32'h5555_5555;
    cyc(1);
    chk("rw_done", bus.o_DDone, 32'd1);
    chk("rw_drdata", bus.o_DRData, 32'h1122_3344);
    bus.i_DRead = 0; bus.i_DWrite = 0; bus.i_MemAck = 0;
    cyc(1);

    // Reset in the second DBUSY cycle with ack in the same cycle
    bus.i_DRead = 1; bus.i_DAddr = 32'h1001_0040;
    cyc(1);
    chk("rb_req", bus.o_MemReq, 32'd1);
    cyc(1);
    rst = 1'b1; bus.i_MemAck = 1; bus.i_MemRData = 32'h9999_9999;
    cyc(1);
    rst = 1'b0; bus.i_MemAck = 0; bus.i_DRead = 0;
    chk("rb_req_drop", bus.o_MemReq, 32'd0);
    chk("rb_nodone", bus.o_DDone, 32'd0);
    chk("rb_drdata", bus.o_DRData, 32'd0);
    cyc(1);
    chk("rb_after", {bus.o_MemReq, bus.o_DDone}, 32'd0);

    // Timeout instance: a good read first, then an unacknowledged read
    bus2.i_DRead = 1; bus2.i_DAddr = 32'h1001_0080;
    cyc(1);
    bus2.i_MemAck = 1; bus2.i_MemRData = 32'hA5A5_A5A5;
    cyc(1);
    chk("to_pre_data", bus2.o_DRData, 32'hA5A5_A5A5);
    bus2.i_DRead = 0; bus2.i_MemAck = 0;
    cyc(1);
    bus2.i_DRead = 1;
    cyc(1);
    chk("to_req", bus2.o_MemReq, 32'd1);
    cyc(3);
    chk("to_wait", {bus2.o_MemReq, bus2.o_DDone, bus2.o_BusErr}, 32'd4);
    cyc(1);
    chk("to_done", bus2.o_DDone, 32'd1);
    chk("to_data", bus2.o_DRData, 32'd0);
    chk("to_err", bus2.o_BusErr, 32'd1);
    chk("to_req_drop", bus2.o_MemReq, 32'd0);
    bus2.i_DRead = 0;
    cyc(3);
    chk("to_err_sticky", {bus2.o_BusErr, bus2.o_DDone}, 32'd2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("to_err_clr", bus2.o_BusErr, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
